// File: rtl/elevator_car.sv
// elevator_car
//   Car/motor model driven by the request handler's {Dir,Process} command.
//   Moves the car one floor per TRAVEL_CYCLES+1 clocks (travel + one ARRIVE
//   cycle), then holds the door open for DOOR_CYCLES clocks.
// Ports
//   clk        : clock, all logic on posedge
//   reset      : synchronous, active-high
//   Dir        : command direction (1 = up)
//   Process    : command active; {Dir,Process} 00 Stop, 11 Up, 01 Down, 10 Stop
//   WhichFloor : current floor, 0..NUM_FLOORS-1
//   Moving     : high while travelling between floors
//   MoveDir    : direction of the current/last segment (1 = up)
//   DoorOpen   : high while the door is open
//   Arrived    : one-cycle pulse on reaching a floor
//   LimitErr   : one-cycle pulse when a move would leave the served range
module elevator_car #(
  parameter int unsigned NUM_FLOORS    = 5,
  parameter int unsigned FLOOR_W       = 5,
  parameter int unsigned TRAVEL_CYCLES = 8,
  parameter int unsigned DOOR_CYCLES   = 4,
  parameter int unsigned RESET_FLOOR   = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               Dir,
  input  logic               Process,
  output logic [FLOOR_W-1:0] WhichFloor,
  output logic               Moving,
  output logic               MoveDir,
  output logic               DoorOpen,
  output logic               Arrived,
  output logic               LimitErr
);

  localparam int unsigned CMAX = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
  localparam int unsigned CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

  localparam logic [FLOOR_W-1:0] TOP_FLOOR = FLOOR_W'(NUM_FLOORS - 1);
  localparam logic [FLOOR_W-1:0] RST_FLOOR = FLOOR_W'(RESET_FLOOR);
  localparam logic [CW-1:0]      TRAVEL_LD = CW'(TRAVEL_CYCLES - 1);
  localparam logic [CW-1:0]      DOOR_LD   = CW'(DOOR_CYCLES - 1);
  localparam logic [CW-1:0]      CNT_ONE   = CW'(1);
  localparam logic [FLOOR_W-1:0] FLOOR_ONE = FLOOR_W'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MOVING,
    S_ARRIVE,
    S_DOOR
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [FLOOR_W-1:0] floor_q, floor_d;
  logic               movedir_q, movedir_d;
  logic               lim_q, lim_d;

  logic cmd_up, cmd_down, at_top, at_bot, cmd_same, same_ok;

  assign cmd_up   = Process & Dir;
  assign cmd_down = Process & ~Dir;
  assign at_top   = (floor_q == TOP_FLOOR);
  assign at_bot   = (floor_q == '0);
  // Continuing request in the latched direction, and whether a floor exists there.
  assign cmd_same = Process & (Dir == movedir_q);
  assign same_ok  = movedir_q ? ~at_top : ~at_bot;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      floor_q   <= RST_FLOOR;
      movedir_q <= 1'b0;
      lim_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      floor_q   <= floor_d;
      movedir_q <= movedir_d;
      lim_q     <= lim_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    floor_d   = floor_q;
    movedir_d = movedir_q;
    lim_d     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if ((cmd_up && !at_top) || (cmd_down && !at_bot)) begin
          state_d   = S_MOVING;
          movedir_d = Dir;
          cnt_d     = TRAVEL_LD;
        end else if ((cmd_up && at_top) || (cmd_down && at_bot)) begin
          lim_d = 1'b1;
        end
      end
      S_MOVING: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_ONE;
        end else begin
          floor_d = movedir_q ? (floor_q + FLOOR_ONE) : (floor_q - FLOOR_ONE);
          state_d = S_ARRIVE;
        end
      end
      S_ARRIVE: begin
        if (cmd_same && same_ok) begin
          state_d = S_MOVING;
          cnt_d   = TRAVEL_LD;
        end else begin
          lim_d   = cmd_same;
          state_d = S_DOOR;
          cnt_d   = DOOR_LD;
        end
      end
      S_DOOR: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_ONE;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from registered state
  always_comb begin
    WhichFloor = floor_q;
    MoveDir    = movedir_q;
    LimitErr   = lim_q;
    Moving     = (state_q == S_MOVING);
    Arrived    = (state_q == S_ARRIVE);
    DoorOpen   = (state_q == S_DOOR);
  end

endmodule

// File: tb/tb_elevator_car.sv
// tb_elevator_car
//   Directed bench for elevator_car (TRAVEL_CYCLES=8, DOOR_CYCLES=4, 5 floors).
//   Each step drives one command, queues the expected post-edge outputs, then
//   compares them 1 time unit after the clock edge.
module tb_elevator_car;

  typedef struct packed {
    logic [4:0] floor;
    logic       mv;
    logic       md;
    logic       door;
    logic       arr;
    logic       lim;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset, Dir, Process;
  logic [4:0] WhichFloor;
  logic       Moving, MoveDir, DoorOpen, Arrived, LimitErr;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  elevator_car #(
    .NUM_FLOORS(5),
    .FLOOR_W(5),
    .TRAVEL_CYCLES(8),
    .DOOR_CYCLES(4),
    .RESET_FLOOR(0)
  ) dut (
    .clk(clk),
    .reset(reset),
    .Dir(Dir),
    .Process(Process),
    .WhichFloor(WhichFloor),
    .Moving(Moving),
    .MoveDir(MoveDir),
    .DoorOpen(DoorOpen),
    .Arrived(Arrived),
    .LimitErr(LimitErr)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input int unsigned f, input logic mv, md, door, arr, lim);
    exp_t e;
    e.floor = 5'(f);
    e.mv    = mv;
    e.md    = md;
    e.door  = door;
    e.arr   = arr;
    e.lim   = lim;
    return e;
  endfunction

  task automatic cyc(input string tag, input logic rst, d, p, input exp_t e);
    exp_t got, want;
    reset   = rst;
    Dir     = d;
    Process = p;
    sb.push_back(e);
    @(posedge clk);
    #1;
    got  = '{WhichFloor, Moving, MoveDir, DoorOpen, Arrived, LimitErr};
    want = sb.pop_front();
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: observed floor=%0d mv=%b md=%b door=%b arr=%b lim=%b expected floor=%0d mv=%b md=%b door=%b arr=%b lim=%b",
             tag, got.floor, got.mv, got.md, got.door, got.arr, got.lim,
             want.floor, want.mv, want.md, want.door, want.arr, want.lim);
    end
  endtask

  initial begin
    reset = 1'b1; Dir = 1'b0; Process = 1'b0;
    #2;

    // Reset state
    cyc("reset", 1, 0, 0, mk(0, 0, 0, 0, 0, 0));
    cyc("reset2", 1, 1, 1, mk(0, 0, 0, 0, 0, 0));

    // Down at floor 0 in IDLE: LimitErr every edge, no motion
    for (int unsigned i = 0; i < 3; i++) cyc("down_at_bottom", 0, 0, 1, mk(0, 0, 0, 0, 0, 1));
    cyc("bottom_release", 0, 0, 0, mk(0, 0, 0, 0, 0, 0));

    // Up held from floor 0 to the top: floor changes every 9 edges
    for (int unsigned s = 0; s < 4; s++) begin
      for (int unsigned i = 0; i < 8; i++) cyc("up_hold_move", 0, 1, 1, mk(s, 1, 1, 0, 0, 0));
      cyc("up_hold_arrive", 0, 1, 1, mk(s + 1, 0, 1, 0, 1, 0));
    end
    cyc("top_limit_arrive", 0, 1, 1, mk(4, 0, 1, 1, 0, 1));
    for (int unsigned i = 0; i < 3; i++) cyc("top_door", 0, 1, 1, mk(4, 0, 1, 1, 0, 0));
    cyc("top_door_close", 0, 1, 1, mk(4, 0, 1, 0, 0, 0));
    cyc("top_limit_idle", 0, 1, 1, mk(4, 0, 1, 0, 0, 1));
    cyc("top_stop", 0, 0, 0, mk(4, 0, 1, 0, 0, 0));

    // One segment down, reverse at ARRIVE opens the door without LimitErr
    for (int unsigned i = 0; i < 8; i++) cyc("down_move", 0, 0, 1, mk(4, 1, 0, 0, 0, 0));
    cyc("down_arrive", 0, 0, 1, mk(3, 0, 0, 0, 1, 0));
    cyc("reverse_door", 0, 1, 1, mk(3, 0, 0, 1, 0, 0));
    for (int unsigned i = 0; i < 3; i++) cyc("down_door", 0, 0, 0, mk(3, 0, 0, 1, 0, 0));
    cyc("down_idle", 0, 0, 0, mk(3, 0, 0, 0, 0, 0));

    // Reset from floor 3
    cyc("reset_mid", 1, 0, 0, mk(0, 0, 0, 0, 0, 0));

    // Up for one cycle then Stop
    cyc("one_up_depart", 0, 1, 1, mk(0, 1, 1, 0, 0, 0));
    for (int unsigned i = 1; i < 8; i++) cyc("one_up_move", 0, 0, 0, mk(0, 1, 1, 0, 0, 0));
    cyc("one_up_arrive", 0, 0, 0, mk(1, 0, 1, 0, 1, 0));
    for (int unsigned i = 0; i < 4; i++) cyc("one_up_door", 0, 0, 0, mk(1, 0, 1, 1, 0, 0));
    cyc("one_up_idle", 0, 0, 0, mk(1, 0, 1, 0, 0, 0));

    // Command changes mid-segment are ignored
    for (int unsigned i = 0; i < 3; i++) cyc("ign_up", 0, 1, 1, mk(1, 1, 1, 0, 0, 0));
    for (int unsigned i = 0; i < 2; i++) cyc("ign_down", 0, 0, 1, mk(1, 1, 1, 0, 0, 0));
    for (int unsigned i = 0; i < 3; i++) cyc("ign_stop", 0, 0, 0, mk(1, 1, 1, 0, 0, 0));
    cyc("ign_arrive", 0, 0, 0, mk(2, 0, 1, 0, 1, 0));
    for (int unsigned i = 0; i < 4; i++) cyc("ign_door", 0, 0, 0, mk(2, 0, 1, 1, 0, 0));
    cyc("ign_idle", 0, 0, 0, mk(2, 0, 1, 0, 0, 0));

    // Up asserted during DOOR departs only after the door closes
    cyc("door_up_depart", 0, 1, 1, mk(2, 1, 1, 0, 0, 0));
    for (int unsigned i = 1; i < 8; i++) cyc("door_up_move", 0, 0, 0, mk(2, 1, 1, 0, 0, 0));
    cyc("door_up_arrive", 0, 0, 0, mk(3, 0, 1, 0, 1, 0));
    cyc("door_up_open", 0, 0, 0, mk(3, 0, 1, 1, 0, 0));
    for (int unsigned i = 0; i < 3; i++) cyc("door_up_held", 0, 1, 1, mk(3, 0, 1, 1, 0, 0));
    cyc("door_up_close", 0, 1, 1, mk(3, 0, 1, 0, 0, 0));
    cyc("door_up_redepart", 0, 1, 1, mk(3, 1, 1, 0, 0, 0));
    for (int unsigned i = 0; i < 4; i++) cyc("seg_before_rst", 0, 1, 1, mk(3, 1, 1, 0, 0, 0));

    // Reset mid-segment wins over a held Up
    cyc("reset_seg", 1, 1, 1, mk(0, 0, 0, 0, 0, 0));

    // Illegal command 10 behaves as Stop
    for (int unsigned i = 0; i < 3; i++) cyc("illegal_cmd", 0, 1, 0, mk(0, 0, 0, 0, 0, 0));
    cyc("post_rst_depart", 0, 1, 1, mk(0, 1, 1, 0, 0, 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
